fetch_unit: RTL and testbench

//  Instruction-fetch stage placed directly upstream of decode. Owns PCF, issues one-outstanding

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_ifid_reg.sv | 51 +++++
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // StDrop* states keep the port protocol alive for a request whose answer is stale.
  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDropReq,
    StDropWait
  } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush and bubble insert NOP_INSTR with valid low, stall holds.
module fetch_ifid_reg #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_stall,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // Flush beats load beats stall; an idle, unstalled cycle becomes a bubble with PCs held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else if (!i_stall) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PCF, single-outstanding imem requests, redirect/stall handling, IF/ID.
module fetch_unit #(
  parameter int unsigned     XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] PcStep      = XLEN'(4);
  localparam logic [XLEN-1:0] PcAlignMask = XLEN'(3);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_fa;         // address of the request on the port / in flight
  logic            r_req;
  logic [31:0]     r_hold_instr; // response captured while decode was stalled
  logic [XLEN-1:0] r_hold_pc;

  logic            w_redirect;
  logic            w_accept;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fa_plus4;

  logic            w_ifid_load;
  logic [31:0]     w_ifid_instr;
  logic [XLEN-1:0] w_ifid_pc;
  logic [XLEN-1:0] w_ifid_pc_plus4;

  // Redirects are not honoured in the single post-reset idle cycle.
  assign w_redirect = PCSrcE && (r_state != StIdle);
  assign w_accept   = r_req && imem_ready;
  assign w_target   = PCTargetE & ~PcAlignMask;
  assign w_fa_plus4 = r_fa + PcStep;

  // Fetch FSM together with PCF, fetch address, request strobe and hold buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_pcf        <= RESET_PC;
      r_fa         <= RESET_PC;
      r_req        <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      // Redirect updates PCF and drops any buffered instruction from any active state.
      if (w_redirect) begin
        r_pcf        <= w_target;
        r_hold_instr <= '0;
        r_hold_pc    <= '0;
      end
      unique case (r_state)
        StIdle: begin
          r_state <= StReq;
          r_fa    <= r_pcf;
          r_req   <= 1'b1;
        end
        StReq: begin
          if (w_redirect) begin
            // The request cannot be retracted; its answer must be swallowed.
            if (w_accept) begin
              r_state <= StDropWait;
              r_req   <= 1'b0;
            end else begin
              r_state <= StDropReq;
            end
          end else if (w_accept) begin
            r_state <= StWait;
            r_req   <= 1'b0;
          end
        end
        StWait: begin
          if (w_redirect) begin
            if (imem_rvalid) begin
              r_state <= StReq;
              r_fa    <= w_target;
              r_req   <= 1'b1;
            end else begin
              r_state <= StDropWait;
            end
          end else if (imem_rvalid) begin
            r_pcf <= w_fa_plus4;
            if (!StallD) begin
              r_state <= StReq;
              r_fa    <= w_fa_plus4;
              r_req   <= 1'b1;
            end else begin
              r_state      <= StHold;
              r_hold_instr <= imem_rdata;
              r_hold_pc    <= r_fa;
            end
          end
        end
        StHold: begin
          if (w_redirect) begin
            r_state <= StReq;
            r_fa    <= w_target;
            r_req   <= 1'b1;
          end else if (!StallD) begin
            r_state <= StReq;
            r_fa    <= r_pcf;
            r_req   <= 1'b1;
          end
        end
        StDropReq: begin
          if (w_accept) begin
            r_state <= StDropWait;
            r_req   <= 1'b0;
          end
        end
        StDropWait: begin
          if (imem_rvalid) begin
            r_state <= StReq;
            r_fa    <= w_redirect ? w_target : r_pcf;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Select what, if anything, is delivered to decode this cycle.
  always_comb begin
    w_ifid_load  = 1'b0;
    w_ifid_instr = r_hold_instr;
    w_ifid_pc    = r_hold_pc;
    if (!w_redirect && !StallD) begin
      if (r_state == StWait && imem_rvalid) begin
        w_ifid_load  = 1'b1;
        w_ifid_instr = imem_rdata;
        w_ifid_pc    = r_fa;
      end else if (r_state == StHold) begin
        w_ifid_load = 1'b1;
      end
    end
    w_ifid_pc_plus4 = w_ifid_pc + PcStep;
  end

  fetch_ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_redirect),
    .i_load     (w_ifid_load),
    .i_stall    (StallD),
    .i_instr    (w_ifid_instr),
    .i_pc       (w_ifid_pc),
    .i_pc_plus4 (w_ifid_pc_plus4),
    .o_instr    (InstrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (ValidD)
  );

  assign imem_req  = r_req;
  assign imem_addr = r_fa;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, transaction-level random model, wrap case.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallD, PCSrcE, imem_ready, imem_rvalid;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

  logic        wr_rst, wr_ready, wr_rvalid;
  logic [31:0] wr_rdata;
  logic        wr_req, wr_valid;
  logic [31:0] wr_addr, wr_instr, wr_pcd, wr_pc4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(wr_rst), .StallD(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
    .imem_req(wr_req), .imem_addr(wr_addr), .imem_ready(wr_ready),
    .imem_rvalid(wr_rvalid), .imem_rdata(wr_rdata), .InstrD(wr_instr), .PCD(wr_pcd),
    .PCPlus4D(wr_pc4), .ValidD(wr_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed per-cycle vectors: inputs for the cycle plus outputs expected during it.
  typedef struct {
    logic        stall, redir;
    logic [31:0] tgt;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pcd, e_pc4;
  } vec_t;

  function automatic vec_t mk(logic st, logic rd, logic [31:0] tg, logic rdy, logic rv,
                              logic [31:0] dat, logic req, logic [31:0] addr, logic vld,
                              logic [31:0] ins, logic [31:0] pcd, logic [31:0] pc4);
    vec_t v;
    v.stall = st; v.redir = rd; v.tgt = tg; v.ready = rdy; v.rvalid = rv; v.rdata = dat;
    v.e_req = req; v.e_addr = addr; v.e_valid = vld; v.e_instr = ins; v.e_pcd = pcd;
    v.e_pc4 = pc4;
    return v;
  endfunction

  // Transaction-level reference: an offered request, an in-flight request, a buffer.
  logic        m_started, m_offer, m_offer_drop, m_wait, m_wait_drop, m_buf_full;
  logic [31:0] m_pcf, m_offer_addr, m_wait_addr, m_buf_instr, m_buf_pc;
  int          m_cnt;
  logic [31:0] e_instr, e_pcd, e_pc4;
  logic        e_valid;

  task automatic model_reset();
    m_started = 1'b0; m_offer = 1'b0; m_wait = 1'b0; m_buf_full = 1'b0;
    m_offer_drop = 1'b0; m_wait_drop = 1'b0; m_pcf = 32'h0; m_cnt = 0;
    m_offer_addr = 32'h0; m_wait_addr = 32'h0; m_buf_instr = 32'h0; m_buf_pc = 32'h0;
    e_instr = Nop; e_pcd = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] tg,
                            input logic rdy, input logic rv, input logic [31:0] dat);
    logic        acc, resp, deliver;
    logic [31:0] d_instr, d_pc;
    deliver = 1'b0; d_instr = 32'h0; d_pc = 32'h0;
    if (!m_started) begin
      m_started = 1'b1;
      m_offer = 1'b1; m_offer_addr = m_pcf; m_offer_drop = 1'b0;
      if (!st) begin e_instr = Nop; e_valid = 1'b0; end
      return;
    end
    acc  = m_offer && rdy;
    resp = m_wait && rv;
    if (resp) begin
      m_wait = 1'b0;
      if (!m_wait_drop && !rd) begin
        m_pcf = m_wait_addr + 32'd4;
        if (!st) begin deliver = 1'b1; d_instr = dat; d_pc = m_wait_addr; end
        else begin m_buf_full = 1'b1; m_buf_instr = dat; m_buf_pc = m_wait_addr; end
      end
    end else if (m_buf_full && !st && !rd) begin
      deliver = 1'b1; d_instr = m_buf_instr; d_pc = m_buf_pc; m_buf_full = 1'b0;
    end
    if (m_wait) begin
      m_cnt--;
      if (rd) m_wait_drop = 1'b1;
    end
    if (acc) begin
      m_offer = 1'b0; m_wait = 1'b1; m_wait_addr = m_offer_addr;
      m_wait_drop = m_offer_drop || rd; m_cnt = $urandom_range(1, 3);
    end else if (m_offer && rd) begin
      m_offer_drop = 1'b1;
    end
    if (rd) begin m_pcf = tg & ~32'd3; m_buf_full = 1'b0; end
    if (!m_offer && !m_wait && !m_buf_full) begin
      m_offer = 1'b1; m_offer_addr = m_pcf; m_offer_drop = 1'b0;
    end
    if (rd) begin e_instr = Nop; e_valid = 1'b0; end
    else if (deliver) begin
      e_instr = d_instr; e_pcd = d_pc; e_pc4 = d_pc + 32'd4; e_valid = 1'b1;
    end else if (!st) begin e_instr = Nop; e_valid = 1'b0; end
  endtask

  vec_t vecs[24];

  initial begin
    //                 st rd tgt        rdy rv data          req addr        v  instr        pcd          pc4
    vecs[0]  = mk(0, 0, 32'h0,   0, 0, 32'h0,    0, 32'h0,   0, Nop,     32'h0,   32'h0);
    vecs[1]  = mk(0, 0, 32'h0,   1, 0, 32'h0,    1, 32'h0,   0, Nop,     32'h0,   32'h0);
    vecs[2]  = mk(0, 0, 32'h0,   0, 1, 32'hA,    0, 32'h0,   0, Nop,     32'h0,   32'h0);
    vecs[3]  = mk(0, 0, 32'h0,   1, 0, 32'h0,    1, 32'h4,   1, 32'hA,   32'h0,   32'h4);
    vecs[4]  = mk(0, 0, 32'h0,   0, 1, 32'hB,    0, 32'h0,   0, Nop,     32'h0,   32'h4);
    vecs[5]  = mk(1, 0, 32'h0,   1, 0, 32'h0,    1, 32'h8,   1, 32'hB,   32'h4,   32'h8);
    vecs[6]  = mk(1, 0, 32'h0,   0, 1, 32'hC,    0, 32'h0,   1, 32'hB,   32'h4,   32'h8);
    vecs[7]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    0, 32'h0,   1, 32'hB,   32'h4,   32'h8);
    vecs[8]  = mk(0, 0, 32'h0,   0, 0, 32'h0,    0, 32'h0,   1, 32'hB,   32'h4,   32'h8);
    vecs[9]  = mk(0, 0, 32'h0,   1, 0, 32'h0,    1, 32'hC,   1, 32'hC,   32'h8,   32'hC);
    vecs[10] = mk(0, 1, 32'h103, 0, 0, 32'h0,    0, 32'h0,   0, Nop,     32'h8,   32'hC);
    vecs[11] = mk(0, 0, 32'h0,   0, 1, 32'hDEAD, 0, 32'h0,   0, Nop,     32'h8,   32'hC);
    vecs[12] = mk(0, 0, 32'h0,   0, 0, 32'h0,    1, 32'h100, 0, Nop,     32'h8,   32'hC);
    vecs[13] = mk(0, 1, 32'h200, 0, 0, 32'h0,    1, 32'h100, 0, Nop,     32'h8,   32'hC);
    vecs[14] = mk(0, 0, 32'h0,   0, 0, 32'h0,    1, 32'h100, 0, Nop,     32'h8,   32'hC);
    vecs[15] = mk(0, 0, 32'h0,   1, 0, 32'h0,    1, 32'h100, 0, Nop,     32'h8,   32'hC);
    vecs[16] = mk(0, 0, 32'h0,   0, 0, 32'h0,    0, 32'h0,   0, Nop,     32'h8,   32'hC);
    vecs[17] = mk(0, 0, 32'h0,   0, 1, 32'hBAD,  0, 32'h0,   0, Nop,     32'h8,   32'hC);
    vecs[18] = mk(0, 0, 32'h0,   1, 0, 32'h0,    1, 32'h200, 0, Nop,     32'h8,   32'hC);
    vecs[19] = mk(0, 0, 32'h0,   0, 1, 32'h11,   0, 32'h0,   0, Nop,     32'h8,   32'hC);
    vecs[20] = mk(0, 0, 32'h0,   0, 0, 32'h0,    1, 32'h204, 1, 32'h11,  32'h200, 32'h204);
    vecs[21] = mk(1, 0, 32'h0,   1, 0, 32'h0,    1, 32'h204, 0, Nop,     32'h200, 32'h204);
    vecs[22] = mk(1, 1, 32'h300, 0, 1, 32'h22,   0, 32'h0,   0, Nop,     32'h200, 32'h204);
    vecs[23] = mk(0, 0, 32'h0,   0, 0, 32'h0,    1, 32'h300, 0, Nop,     32'h200, 32'h204);

    rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    wr_rst = 1'b1; wr_ready = 1'b0; wr_rvalid = 1'b0; wr_rdata = 32'h0;

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    chk("reset ValidD", {31'h0, ValidD}, 32'h0);
    chk("reset InstrD", InstrD, Nop);
    chk("reset imem_req", {31'h0, imem_req}, 32'h0);
    chk("reset PCD", PCD, 32'h0);
    rst = 1'b0;

    // Directed table: sequential fetch, stall/hold, redirects in WAIT and unaccepted REQ.
    for (int i = 0; i < 24; i++) begin
      StallD = vecs[i].stall; PCSrcE = vecs[i].redir; PCTargetE = vecs[i].tgt;
      imem_ready = vecs[i].ready; imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d ValidD", i), {31'h0, ValidD}, {31'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d InstrD", i), InstrD, vecs[i].e_instr);
      chk($sformatf("vec%0d PCD", i), PCD, vecs[i].e_pcd);
      chk($sformatf("vec%0d PCPlus4D", i), PCPlus4D, vecs[i].e_pc4);
      @(negedge clk);
    end

    // Random traffic against the reference model, including a mid-run reset.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c > 1) begin
        chk("rnd imem_req", {31'h0, imem_req}, {31'h0, m_offer});
        if (m_offer) chk("rnd imem_addr", imem_addr, m_offer_addr);
        chk("rnd ValidD", {31'h0, ValidD}, {31'h0, e_valid});
        chk("rnd InstrD", InstrD, e_instr);
        chk("rnd PCD", PCD, e_pcd);
        chk("rnd PCPlus4D", PCPlus4D, e_pc4);
      end
      StallD     = ($urandom_range(0, 3) == 0);
      PCSrcE     = ($urandom_range(0, 11) == 0);
      PCTargetE  = $urandom;
      imem_ready = ($urandom_range(0, 3) != 0);
      imem_rdata = $urandom;
      if (c < 2 || c == 1700) begin
        rst = 1'b1; imem_rvalid = 1'b0;
        model_reset();
      end else begin
        rst = 1'b0;
        imem_rvalid = m_wait && (m_cnt == 1);
        model_step(StallD, PCSrcE, PCTargetE, imem_ready, imem_rvalid, imem_rdata);
      end
      @(negedge clk);
    end
    rst = 1'b0; PCSrcE = 1'b0; imem_rvalid = 1'b0;

    // Wrap: first fetch at 0xFFFFFFFC, next address and PCPlus4D wrap to 0.
    wr_rst = 1'b0;
    @(negedge clk);
    chk("wrap first req", {31'h0, wr_req}, 32'h1);
    chk("wrap first addr", wr_addr, 32'hFFFF_FFFC);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0; wr_rvalid = 1'b1; wr_rdata = 32'h77;
    @(negedge clk);
    wr_rvalid = 1'b0;
    chk("wrap second req", {31'h0, wr_req}, 32'h1);
    chk("wrap second addr", wr_addr, 32'h0);
    chk("wrap ValidD", {31'h0, wr_valid}, 32'h1);
    chk("wrap InstrD", wr_instr, 32'h77);
    chk("wrap PCD", wr_pcd, 32'hFFFF_FFFC);
    chk("wrap PCPlus4D", wr_pc4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
